// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state encodings shared by seq_alu and its multiplier
package alu_pkg;
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_SLT = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HOLD
  } state_e;
endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: unsigned WIDTH x WIDTH shift-add multiplier, one iteration per cycle
module mul_shift_add #(
  parameter int WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]      cnt;
  logic               busy;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  // product is the accumulator after the current iteration, so the parent can capture it on the final edge
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(WIDTH - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, X};
      mplier <= Y;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      busy   <= !done;
    end
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered outputs (ADD, SUB, multi-cycle MUL, SLT)
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             Cout,
  output logic             Overflow
);
  state_e             state;
  op_e                op;
  logic               sub;
  logic [WIDTH-1:0]   yb;
  logic [WIDTH:0]     sum;
  logic               ovf;
  logic               lt;
  logic [WIDTH-1:0]   alu_f;
  logic               start;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;
  assign op    = op_e'(S);
  assign sub   = op == OP_SUB;
  assign yb    = sub ? ~Y : Y;
  assign sum   = {1'b0, X} + {1'b0, yb} + {{WIDTH{1'b0}}, sub};
  // SUB overflow is ADD overflow on X + ~Y: X and Y differ in sign iff X and ~Y agree
  assign ovf   = (X[WIDTH-1] == yb[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
  assign lt    = $signed(X) < $signed(Y);
  assign alu_f = op == OP_SLT ? {{(WIDTH-1){1'b0}}, lt} : sum[WIDTH-1:0];
  assign start = in_valid && state == S_IDLE && op == OP_MUL;
  mul_shift_add #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(start),
    .X(X),
    .Y(Y),
    .done(mul_done),
    .product(product)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      F         <= '0;
      Cout      <= 1'b0;
      Overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          if (op == OP_MUL) begin
            state <= S_MUL;
          end else begin
            state     <= S_HOLD;
            out_valid <= 1'b1;
            F         <= alu_f;
            Cout      <= op == OP_SLT ? 1'b0 : sum[WIDTH];
            Overflow  <= op == OP_SLT ? 1'b0 : ovf;
          end
        end
        S_MUL: if (mul_done) begin
          state     <= S_HOLD;
          out_valid <= 1'b1;
          F         <= product[WIDTH-1:0];
          Cout      <= |product[2*WIDTH-1:WIDTH];
          Overflow  <= |product[2*WIDTH-1:WIDTH];
        end
        S_HOLD: if (out_ready) begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with a queue scoreboard checked by an independent monitor
module tb_seq_alu;
  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0;
  logic       in_ready;
  logic [1:0] S = 0;
  logic [4:0] X = 0;
  logic [4:0] Y = 0;
  logic       out_valid;
  logic       out_ready = 1;
  logic [4:0] F;
  logic       Cout;
  logic       Overflow;
  int tests = 0;
  int fails = 0;
  logic [6:0] q[$];
  seq_alu #(.WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .S(S), .X(X), .Y(Y),
    .out_valid(out_valid), .out_ready(out_ready), .F(F), .Cout(Cout), .Overflow(Overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected result F=%b Cout=%b Ovf=%b", F, Cout, Overflow);
      end else begin
        logic [6:0] e;
        e = q.pop_front();
        if ({F, Cout, Overflow} != e) begin
          fails++;
          $display("FAIL result: got F=%b C=%b O=%b expected F=%b C=%b O=%b",
                   F, Cout, Overflow, e[6:2], e[1], e[0]);
        end
      end
    end
  end
  task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic push, input logic [6:0] e);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready timeout", 0, 1);
    in_valid = 1; S = op; X = a; Y = b;
    if (push) q.push_back(e);
    @(posedge clk); #1;
    in_valid = 0;
    S = 2'($urandom); X = 5'($urandom); Y = 5'($urandom);
  endtask
  task automatic latency(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  initial begin
    int n;
    logic [4:0] f0;
    @(posedge clk); #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset F", F, 0);
    chk("reset Cout/Ovf", {Cout, Overflow}, 0);
    @(posedge clk); #1;
    rst = 0;
    issue(2'b00, 5'b00110, 5'b00111, 1, {5'b01101, 2'b00});
    latency(n); chk("ADD latency", n, 1);
    issue(2'b00, 5'b01111, 5'b00001, 1, {5'b10000, 2'b01});
    issue(2'b00, 5'b11111, 5'b11111, 1, {5'b11110, 2'b10});
    issue(2'b01, 5'b00000, 5'b00001, 1, {5'b11111, 2'b00});
    issue(2'b01, 5'b10000, 5'b00001, 1, {5'b01111, 2'b11});
    issue(2'b11, 5'b11111, 5'b00001, 1, {5'b00001, 2'b00});
    issue(2'b11, 5'b00001, 5'b11111, 1, {5'b00000, 2'b00});
    issue(2'b10, 5'b00111, 5'b00101, 1, {5'b00011, 2'b11});
    latency(n); chk("MUL latency", n, 6);
    issue(2'b10, 5'b00011, 5'b00010, 1, {5'b00110, 2'b00});
    issue(2'b10, 5'b11111, 5'b11111, 1, {5'b00001, 2'b11});
    latency(n); chk("MUL 31x31 latency", n, 6);
    // backpressure: result must hold and a competing request must be ignored
    @(posedge clk); #1;
    out_ready = 0;
    issue(2'b00, 5'b00001, 5'b00010, 1, {5'b00011, 2'b00});
    f0 = F;
    chk("bp F", f0, 3);
    in_valid = 1; S = 2'b00; X = 5'b00101; Y = 5'b00101;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp stable", {F, out_valid, in_ready}, {f0, 1'b1, 1'b0});
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp release in_ready", in_ready, 1);
    chk("bp release out_valid", out_valid, 0);
    out_ready = 1;
    // reset in the middle of a multiply discards it
    issue(2'b10, 5'b00111, 5'b00101, 0, 7'd0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst mid-MUL out_valid", out_valid, 0);
    chk("rst mid-MUL in_ready", in_ready, 1);
    chk("rst mid-MUL F", F, 0);
    chk("rst mid-MUL Cout/Ovf", {Cout, Overflow}, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("no stray result", out_valid, 0);
    issue(2'b00, 5'b00001, 5'b00001, 1, {5'b00010, 2'b00});
    latency(n); chk("post-reset ADD latency", n, 1);
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
